// File: rtl/axi_write_gate_pkg.sv
// Shared AXI channel/struct layout and burst-length type for the write gate.
package axi_write_gate_pkg;

    typedef logic [7:0]  len_t;
    typedef logic [3:0]  id_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
    } aw_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_write_gate_fifo.sv
// Small register FIFO with the common_cells fifo_v3 port shape (usage output omitted).
module axi_write_gate_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 4,
    parameter type         dtype        = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic testmode_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(DEPTH - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0]  OneCnt  = CntW'(1);

    dtype             mem_q [DEPTH];
    logic [AddrW-1:0] wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             bypass, do_push, do_pop;
    logic             unused_testmode;

    assign unused_testmode = testmode_i;

    // In fall-through mode an empty FIFO hands push data straight to the reader.
    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign data_o  = (FALL_THROUGH && cnt_q == '0) ? data_i : mem_q[rd_q];
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == LastPtr) ? '0 : wr_q + AddrW'(1);
            if (do_pop)  rd_q <= (rd_q == LastPtr) ? '0 : rd_q + AddrW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + OneCnt;
            else if (do_pop && !do_push) cnt_q <= cnt_q - OneCnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/axi_write_gate.sv
// Write-path gate: holds W until its AW is accepted, bounds outstanding writes,
// and regenerates w.last from the recorded burst length.
module axi_write_gate
    import axi_write_gate_pkg::*;
#(
    parameter int unsigned MaxTxns    = 4,
    parameter type         axi_req_t  = req_t,
    parameter type         axi_resp_t = resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    output logic      busy_o,
    output logic      wlast_err_o
);

    localparam int unsigned CntW = $clog2(MaxTxns + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    logic [CntW-1:0] outst_q;
    logic [7:0]      beat_q;
    logic            wlast_err_q;
    logic            fifo_full, fifo_empty;
    len_t            fifo_head;
    logic            aw_en, w_en, aw_hs, w_hs, b_hs, calc_last;
    logic            unused_fields;

    assign unused_fields = ^{slv_req_i.ar, slv_req_i.ar_valid, slv_req_i.r_ready,
                             mst_resp_i.ar_ready, mst_resp_i.r, mst_resp_i.r_valid};

    assign aw_en     = (outst_q < MaxCnt) && !fifo_full;
    assign w_en      = !fifo_empty;
    assign calc_last = (beat_q == fifo_head);

    assign aw_hs = slv_req_i.aw_valid && mst_resp_i.aw_ready && aw_en;
    assign w_hs  = slv_req_i.w_valid && mst_resp_i.w_ready && w_en;
    assign b_hs  = mst_resp_i.b_valid && slv_req_i.b_ready;

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = slv_req_i.aw;
        mst_req_o.aw_valid = slv_req_i.aw_valid && aw_en;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w.last   = calc_last;
        mst_req_o.w_valid  = slv_req_i.w_valid && w_en;
        mst_req_o.b_ready  = slv_req_i.b_ready;
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_en;
        slv_resp_o.w_ready  = mst_resp_i.w_ready && w_en;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.b        = mst_resp_i.b;
    end

    // Non-fall-through: a burst's W can only start the cycle after its AW.
    axi_write_gate_fifo #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxTxns),
        .dtype        (len_t)
    ) i_len_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .data_i     (slv_req_i.aw.len),
        .push_i     (aw_hs),
        .data_o     (fifo_head),
        .pop_i      (w_hs && calc_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q     <= '0;
            beat_q      <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            // A stray B at zero must never wrap the counter.
            if (aw_hs && !b_hs)                        outst_q <= outst_q + OneCnt;
            else if (b_hs && !aw_hs && outst_q != '0)  outst_q <= outst_q - OneCnt;
            if (w_hs) begin
                beat_q <= calc_last ? 8'd0 : beat_q + 8'd1;
                if (slv_req_i.w.last != calc_last) wlast_err_q <= 1'b1;
            end
        end
    end

    assign busy_o      = (outst_q != '0);
    assign wlast_err_o = wlast_err_q;

    b_hs_with_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) b_hs |-> (outst_q != '0));

    no_r_valid: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !mst_resp_i.r_valid);

endmodule

// File: tb/tb_axi_write_gate.sv
// Directed bench for axi_write_gate: combinational gating table plus multi-cycle sequences.
module tb_axi_write_gate;
    import axi_write_gate_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    req_t  slv_req, mst_req;
    resp_t slv_resp, mst_resp;
    logic  busy, wlast_err;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    axi_write_gate #(
        .MaxTxns (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .busy_o      (busy),
        .wlast_err_o (wlast_err)
    );

    typedef struct {
        logic       aw_v, aw_r, w_v, w_r, b_v, b_r;
        logic [5:0] exp;  // {mst aw_valid, slv aw_ready, mst w_valid, slv w_ready, slv b_valid, mst b_ready}
    } vec_t;

    vec_t vecs[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle just after the falling edge; outputs are settled 1 time unit later.
    task automatic step(input logic aw_v, input len_t len, input logic w_v,
                        input logic [31:0] data, input logic wl, input logic b_v);
        @(negedge clk);
        slv_req.aw_valid  = aw_v;
        slv_req.aw.len    = len;
        slv_req.aw.addr   = 32'h1000 + 32'(len);
        slv_req.w_valid   = w_v;
        slv_req.w.data    = data;
        slv_req.w.last    = wl;
        slv_req.w.strb    = 4'hf;
        slv_req.b_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.b_valid  = b_v;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{aw_v:1, aw_r:1, w_v:1, w_r:1, b_v:0, b_r:0, exp:6'b110000};
        vecs[1] = '{aw_v:1, aw_r:0, w_v:0, w_r:1, b_v:1, b_r:0, exp:6'b100010};
        vecs[2] = '{aw_v:0, aw_r:1, w_v:1, w_r:0, b_v:0, b_r:1, exp:6'b010001};
        vecs[3] = '{aw_v:0, aw_r:0, w_v:0, w_r:0, b_v:1, b_r:1, exp:6'b000011};
        vecs[4] = '{aw_v:0, aw_r:0, w_v:0, w_r:0, b_v:0, b_r:0, exp:6'b000000};

        slv_req  = '0;
        mst_resp = '0;
        mst_resp.b.id   = 4'h5;
        mst_resp.b.resp = 2'b10;
        rst_n = 1'b0;
        slv_req.w_valid  = 1'b1;
        mst_resp.w_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_wlast_err", wlast_err, 1'b0);
        chk1("reset_mst_w_valid", mst_req.w_valid, 1'b0);
        chk1("reset_slv_w_ready", slv_resp.w_ready, 1'b0);
        @(negedge clk);
        slv_req.w_valid = 1'b0;
        rst_n = 1'b1;

        // Idle-state gating table; valids are dropped before the next rising edge.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            slv_req.aw_valid  = vecs[i].aw_v;
            mst_resp.aw_ready = vecs[i].aw_r;
            slv_req.w_valid   = vecs[i].w_v;
            mst_resp.w_ready  = vecs[i].w_r;
            mst_resp.b_valid  = vecs[i].b_v;
            slv_req.b_ready   = vecs[i].b_r;
            slv_req.ar_valid  = 1'b1;
            slv_req.r_ready   = 1'b1;
            mst_resp.ar_ready = 1'b1;
            #1;
            chk("table_gating", 32'({mst_req.aw_valid, slv_resp.aw_ready, mst_req.w_valid,
                                     slv_resp.w_ready, slv_resp.b_valid, mst_req.b_ready}),
                32'(vecs[i].exp));
            chk("table_ar_r_tied", 32'({mst_req.ar_valid, mst_req.r_ready,
                                        slv_resp.ar_ready, slv_resp.r_valid}), 32'h0);
            slv_req.aw_valid  = 1'b0;
            slv_req.w_valid   = 1'b0;
            mst_resp.b_valid  = 1'b0;
            slv_req.ar_valid  = 1'b0;
            slv_req.r_ready   = 1'b0;
            mst_resp.ar_ready = 1'b0;
        end

        // AW len=3 followed by four W beats.
        step(1, 8'd3, 1, 32'hA000_0000, 0, 0);
        chk1("t1_mst_aw_valid", mst_req.aw_valid, 1'b1);
        chk1("t1_slv_aw_ready", slv_resp.aw_ready, 1'b1);
        chk("t1_aw_addr", mst_req.aw.addr, 32'h1003);
        chk1("t1_w_held_same_cycle", mst_req.w_valid, 1'b0);
        chk1("t1_w_ready_held", slv_resp.w_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'd0, 1, 32'hA000_0000 + 32'(i), (i == 3), 0);
            chk1("t1_w_valid", mst_req.w_valid, 1'b1);
            chk1("t1_w_last", mst_req.w.last, (i == 3));
            chk("t1_w_data", mst_req.w.data, 32'hA000_0000 + 32'(i));
            chk1("t1_busy", busy, 1'b1);
        end
        step(0, 8'd0, 0, 32'h0, 0, 1);
        chk1("t1_b_valid", slv_resp.b_valid, 1'b1);
        chk1("t1_b_ready", mst_req.b_ready, 1'b1);
        chk("t1_b_id", 32'(slv_resp.b.id), 32'h5);
        chk1("t1_busy_at_b", busy, 1'b1);
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t1_busy_after_b", busy, 1'b0);
        chk1("t1_wlast_err", wlast_err, 1'b0);

        // W offered five cycles ahead of its AW.
        for (int k = 0; k < 5; k++) begin
            step(0, 8'd0, 1, 32'hCAFE_0001, 1, 0);
            chk1("t2_w_blocked", mst_req.w_valid, 1'b0);
        end
        step(1, 8'd0, 1, 32'hCAFE_0001, 1, 0);
        chk1("t2_w_blocked_at_aw", mst_req.w_valid, 1'b0);
        chk1("t2_aw_ready", slv_resp.aw_ready, 1'b1);
        step(0, 8'd0, 1, 32'hCAFE_0001, 1, 0);
        chk1("t2_w_released", mst_req.w_valid, 1'b1);
        chk("t2_w_data", mst_req.w.data, 32'hCAFE_0001);
        chk1("t2_w_last", mst_req.w.last, 1'b1);
        step(0, 8'd0, 0, 32'h0, 0, 1);
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t2_busy_done", busy, 1'b0);

        // Outstanding limit of two, then simultaneous AW and B.
        step(1, 8'd0, 0, 32'h0, 0, 0);
        chk1("t3_aw1_ready", slv_resp.aw_ready, 1'b1);
        step(1, 8'd0, 1, 32'hB000_0001, 1, 0);
        chk1("t3_aw2_ready", slv_resp.aw_ready, 1'b1);
        chk1("t3_w1_valid", mst_req.w_valid, 1'b1);
        step(1, 8'd0, 1, 32'hB000_0002, 1, 0);
        chk1("t3_aw3_stall", slv_resp.aw_ready, 1'b0);
        chk1("t3_aw3_mst_valid", mst_req.aw_valid, 1'b0);
        chk1("t3_w2_valid", mst_req.w_valid, 1'b1);
        step(1, 8'd0, 0, 32'h0, 0, 0);
        chk1("t3_aw3_still_stalled", slv_resp.aw_ready, 1'b0);
        step(1, 8'd0, 0, 32'h0, 0, 1);
        chk1("t3_stall_during_b", slv_resp.aw_ready, 1'b0);
        chk1("t3_b_valid", slv_resp.b_valid, 1'b1);
        step(1, 8'd0, 0, 32'h0, 0, 0);
        chk1("t3_aw3_after_b", slv_resp.aw_ready, 1'b1);
        step(0, 8'd0, 1, 32'hB000_0003, 1, 1);
        chk1("t3_w3_last", mst_req.w.last, 1'b1);
        step(1, 8'd0, 0, 32'h0, 0, 1);
        chk1("t4_aw_with_b", slv_resp.aw_ready, 1'b1);
        chk1("t4_b_with_aw", slv_resp.b_valid, 1'b1);
        step(1, 8'd0, 0, 32'h0, 0, 0);
        chk1("t4_one_outstanding", slv_resp.aw_ready, 1'b1);
        chk1("t4_busy", busy, 1'b1);
        step(1, 8'd0, 0, 32'h0, 0, 0);
        chk1("t4_limit_reached", slv_resp.aw_ready, 1'b0);
        step(0, 8'd0, 1, 32'hB000_0004, 1, 1);
        step(0, 8'd0, 1, 32'hB000_0005, 1, 1);
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t4_drained", busy, 1'b0);

        // Slave asserts last one beat early on a len=1 burst.
        chk1("t5_err_before", wlast_err, 1'b0);
        step(1, 8'd1, 0, 32'h0, 0, 0);
        step(0, 8'd0, 1, 32'hC000_0000, 1, 0);
        chk1("t5_beat0_last", mst_req.w.last, 1'b0);
        step(0, 8'd0, 1, 32'hC000_0001, 1, 0);
        chk1("t5_beat1_last", mst_req.w.last, 1'b1);
        chk1("t5_err_set", wlast_err, 1'b1);
        step(0, 8'd0, 0, 32'h0, 0, 1);
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t5_busy_done", busy, 1'b0);
        repeat (3) step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t5_err_sticky", wlast_err, 1'b1);

        // Asynchronous reset after two of four beats.
        step(1, 8'd3, 0, 32'h0, 0, 0);
        step(0, 8'd0, 1, 32'hD000_0000, 0, 0);
        step(0, 8'd0, 1, 32'hD000_0001, 0, 0);
        step(0, 8'd0, 1, 32'hD000_0002, 0, 0);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd0;
        #1 rst_n = 1'b0;
        #1;
        chk1("t6_busy_cleared", busy, 1'b0);
        chk1("t6_err_cleared", wlast_err, 1'b0);
        chk1("t6_w_valid_cleared", mst_req.w_valid, 1'b0);
        chk1("t6_w_ready_cleared", slv_resp.w_ready, 1'b0);
        chk1("t6_aw_transparent", mst_req.aw_valid, 1'b1);
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        rst_n = 1'b1;
        step(1, 8'd0, 1, 32'hE000_0000, 1, 0);
        chk1("t6_fresh_w_held", mst_req.w_valid, 1'b0);
        step(0, 8'd0, 1, 32'hE000_0000, 1, 0);
        chk1("t6_fresh_w_valid", mst_req.w_valid, 1'b1);
        chk1("t6_fresh_w_last", mst_req.w.last, 1'b1);
        step(0, 8'd0, 0, 32'h0, 0, 1);
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t6_busy_done", busy, 1'b0);
        chk1("t6_no_err", wlast_err, 1'b0);

        // Maximum burst length 255: 256 beats, last only on the final one.
        step(1, 8'd255, 0, 32'h0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            step(0, 8'd0, 1, 32'(i), (i == 255), 0);
            chk1("t7_long_last", mst_req.w.last, (i == 255));
        end
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t7_busy_before_b", busy, 1'b1);
        step(0, 8'd0, 0, 32'h0, 0, 1);
        step(0, 8'd0, 0, 32'h0, 0, 0);
        chk1("t7_busy_done", busy, 1'b0);
        chk1("t7_no_err", wlast_err, 1'b0);
        step(0, 8'd0, 1, 32'h0, 1, 0);
        chk1("t7_fifo_empty_after", mst_req.w_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
